debounce_switch_bank: RTL and testbench
=======================================

Name: debounce_switch_bank

Overview:
- Multi-channel, parametrised switch debouncer for the board's push-buttons and slide switches.
- Each channel synchronises its raw input, debounces it with its own counter, and outputs:
  - a stable level;
  - one-cycle press and release strobes;
  - an optional one-cycle long-press strobe.
- Sits between board pins and any logic that needs clean button events, such as menu FSMs and counters.

Parameters:
- NUM_SWITCHES, 4, number of independent channels (>=1).
- DEBOUNCE_LIMIT, 250000, consecutive differing cycles needed to accept a new level (>=1; 10 ms at 25 MHz).
- HOLD_LIMIT, 0, cycles the debounced level must stay 1 before o_Hold pulses; 0 disables hold detection.
- ACTIVE_LOW, 0, when 1, each i_Switch bit is inverted before the synchroniser, so "1" means pressed internally.

Ports:
- i_Clk, input, 1, system clock.
- i_Reset, input, 1, synchronous active-high reset.
- i_Switch, input, NUM_SWITCHES, raw asynchronous switch pins.
- o_Switch, output, NUM_SWITCHES, debounced level per channel.
- o_Press, output, NUM_SWITCHES, one-cycle pulse on debounced 0->1.
- o_Release, output, NUM_SWITCHES, one-cycle pulse on debounced 1->0.
- o_Hold, output, NUM_SWITCHES, one-cycle pulse when the level has been 1 for HOLD_LIMIT cycles.

Behaviour:
- **Clock and reset:** one clock, i_Clk. Reset is synchronous and active-high on i_Reset.
- **Reset values:** on a clock edge with i_Reset=1, every one of the following clears to 0:
  - synchroniser flops;
  - debounced states;
  - debounce counters and hold counters;
  - hold-done flags;
  - o_Switch, o_Press, o_Release, o_Hold.
- **Reset mid-operation:** reset aborts any in-progress count. A level held at 1 through reset must be re-debounced in full.
- **Channel independence:** channels are fully independent; there is no shared counter.
- **Synchroniser:** a 2-flop synchroniser per channel (after optional inversion) produces s[i].
- **Debounce counter:**
  - Width is $clog2(DEBOUNCE_LIMIT+1); it must never overflow.
  - Each edge: if s[i]==state[i], cnt<=0.
  - Else if cnt==DEBOUNCE_LIMIT-1: state[i]<=s[i] and cnt<=0.
  - Else cnt<=cnt+1.
- **Debounce latency:**
  - The new level is accepted only after DEBOUNCE_LIMIT consecutive differing s samples.
  - Any single matching sample restarts the count.
  - If edge k is the first to sample a new stable pin level into flop 1, state and o_Switch change at edge k+1+DEBOUNCE_LIMIT.
- **DEBOUNCE_LIMIT=1:** state follows s with one cycle of delay.
- **Press/release strobes:**
  - o_Press[i] and o_Release[i] are registered.
  - Each is high for exactly the one cycle following the edge at which state[i] changes 0->1 or 1->0 respectively.
  - They are never both high on the same channel.
- **Hold counter:**
  - Width is $clog2(HOLD_LIMIT+1).
  - Clears while state[i]==0.
  - Increments while state[i]==1 and it is below HOLD_LIMIT, then saturates.
- **Hold strobe:**
  - o_Hold[i] pulses for one cycle on the edge where the count reaches HOLD_LIMIT.
  - It pulses at most once per press; the hold-done flag clears on release.
  - A release on the same edge the count would reach the limit produces no o_Hold.
  - If HOLD_LIMIT=0, o_Hold is tied to 0 and no hold logic is generated.
- **Simultaneous activity:** simultaneous changes on several channels are each handled independently in the same cycle.

Test Plan (NUM_SWITCHES=2, DEBOUNCE_LIMIT=8, HOLD_LIMIT=20, ACTIVE_LOW=0 unless stated):
- **Clean press:** set i_Switch[0]=1 and hold.
  - o_Switch[0] rises exactly 9 edges after the first sampling edge.
  - o_Press[0] is high for 1 cycle.
  - Channel 1 outputs stay 0.
- **Bounce rejection:** toggle i_Switch[0] high for 5 cycles, low for 1, repeated 10 times, then hold high.
  - No o_Switch change during the bounce.
  - o_Switch rises 9 edges after the final stable sampling edge.
- **Release and hold:**
  - Press ch0 and hold for 40 cycles: o_Hold[0] pulses once, exactly 20 cycles after o_Switch[0] rises.
  - Release: o_Release[0] pulses once, and no further o_Hold pulse occurs.
  - A press of 15 cycles produces no o_Hold.
- **Reset mid-count:**
  - Raise i_Switch[1]; assert i_Reset for 1 cycle after 5 counting cycles.
  - All outputs are 0 after reset.
  - o_Switch[1] rises only after a full 8-cycle count plus synchroniser delay, measured from reset release.
- **Parallel channels:** raise both channels on the same cycle.
  - Both o_Switch bits rise and both o_Press bits pulse on the identical cycle.
- **ACTIVE_LOW=1:**
  - After reset, i_Switch=2'b11 keeps all outputs at 0.
  - Driving bit 0 low gives o_Switch[0]=1 after 9 edges.

Source files
------------

// File: rtl/debounce_switch_bank.sv
// debounce_switch_bank: per-channel synchroniser, debounce counter, press/release strobes and
// an optional long-press (hold) strobe. Every channel has its own counters; nothing is shared.
module debounce_switch_bank #(
    parameter int unsigned NUM_SWITCHES   = 4,
    parameter int unsigned DEBOUNCE_LIMIT = 250000,
    parameter int unsigned HOLD_LIMIT     = 0,
    parameter bit          ACTIVE_LOW     = 1'b0
) (
    input  logic                    i_Clk,
    input  logic                    i_Reset,
    input  logic [NUM_SWITCHES-1:0] i_Switch,
    output logic [NUM_SWITCHES-1:0] o_Switch,
    output logic [NUM_SWITCHES-1:0] o_Press,
    output logic [NUM_SWITCHES-1:0] o_Release,
    output logic [NUM_SWITCHES-1:0] o_Hold
);

    // Sized so the counter can hold DEBOUNCE_LIMIT without wrapping; it never exceeds LIMIT-1.
    localparam int unsigned         DbCntW    = $clog2(DEBOUNCE_LIMIT + 1);
    localparam logic [DbCntW-1:0]   DbCntLast = DbCntW'(DEBOUNCE_LIMIT - 1);

    logic [NUM_SWITCHES-1:0] pin_in;
    logic [NUM_SWITCHES-1:0] sync1_q;
    logic [NUM_SWITCHES-1:0] sync2_q;
    logic [NUM_SWITCHES-1:0] state_q;
    logic [NUM_SWITCHES-1:0] state_d;
    logic [NUM_SWITCHES-1:0] press_q;
    logic [NUM_SWITCHES-1:0] release_q;

    // Internally "1" always means pressed, whatever the pin polarity.
    assign pin_in = ACTIVE_LOW ? ~i_Switch : i_Switch;

    // Two-flop synchroniser for the asynchronous pins.
    always_ff @(posedge i_Clk) begin
        if (i_Reset) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= pin_in;
            sync2_q <= sync1_q;
        end
    end

    for (genvar ch = 0; ch < NUM_SWITCHES; ch++) begin : g_chan
        logic [DbCntW-1:0] db_cnt_q;
        logic [DbCntW-1:0] db_cnt_d;
        logic              ch_state_d;

        // Count consecutive samples that disagree with the accepted level; any agreement restarts.
        always_comb begin
            db_cnt_d   = db_cnt_q;
            ch_state_d = state_q[ch];
            if (sync2_q[ch] == state_q[ch]) begin
                db_cnt_d = '0;
            end else if (db_cnt_q == DbCntLast) begin
                ch_state_d = sync2_q[ch];
                db_cnt_d   = '0;
            end else begin
                db_cnt_d = db_cnt_q + 1'b1;
            end
        end

        // Debounce counter register.
        always_ff @(posedge i_Clk) begin
            if (i_Reset) begin
                db_cnt_q <= '0;
            end else begin
                db_cnt_q <= db_cnt_d;
            end
        end

        assign state_d[ch] = ch_state_d;
    end

    // Debounced level plus registered edge strobes; press and release are mutually exclusive.
    always_ff @(posedge i_Clk) begin
        if (i_Reset) begin
            state_q   <= '0;
            press_q   <= '0;
            release_q <= '0;
        end else begin
            state_q   <= state_d;
            press_q   <= state_d & ~state_q;
            release_q <= ~state_d & state_q;
        end
    end

    assign o_Switch  = state_q;
    assign o_Press   = press_q;
    assign o_Release = release_q;

    if (HOLD_LIMIT > 0) begin : g_hold
        localparam int unsigned           HoldCntW    = $clog2(HOLD_LIMIT + 1);
        localparam logic [HoldCntW-1:0]   HoldCntLast = HoldCntW'(HOLD_LIMIT - 1);
        localparam logic [HoldCntW-1:0]   HoldCntMax  = HoldCntW'(HOLD_LIMIT);

        for (genvar ch = 0; ch < NUM_SWITCHES; ch++) begin : g_hold_chan
            logic [HoldCntW-1:0] hold_cnt_q;
            logic [HoldCntW-1:0] hold_cnt_d;
            logic                hold_done_q;
            logic                hold_done_d;
            logic                hold_pulse_q;
            logic                hold_pulse_d;

            // Saturating time-held counter; the pulse is suppressed if the level drops on the
            // very edge the limit is reached, and the done flag limits it to one per press.
            always_comb begin
                hold_cnt_d   = hold_cnt_q;
                hold_done_d  = hold_done_q;
                hold_pulse_d = 1'b0;
                if (!state_q[ch]) begin
                    hold_cnt_d  = '0;
                    hold_done_d = 1'b0;
                end else if (hold_cnt_q != HoldCntMax) begin
                    hold_cnt_d = hold_cnt_q + 1'b1;
                    if ((hold_cnt_q == HoldCntLast) && state_d[ch] && !hold_done_q) begin
                        hold_pulse_d = 1'b1;
                        hold_done_d  = 1'b1;
                    end
                end
            end

            // Hold counter, done flag and registered hold strobe.
            always_ff @(posedge i_Clk) begin
                if (i_Reset) begin
                    hold_cnt_q   <= '0;
                    hold_done_q  <= 1'b0;
                    hold_pulse_q <= 1'b0;
                end else begin
                    hold_cnt_q   <= hold_cnt_d;
                    hold_done_q  <= hold_done_d;
                    hold_pulse_q <= hold_pulse_d;
                end
            end

            assign o_Hold[ch] = hold_pulse_q;
        end
    end else begin : g_no_hold
        assign o_Hold = '0;
    end

endmodule

// File: tb/tb_debounce_switch_bank.sv
// Bench for debounce_switch_bank: an active-high and an active-low instance, a behavioural
// per-channel model compared every cycle, plus directed latency/strobe checks.
module tb_debounce_switch_bank;

    localparam int NSW = 2;
    localparam int DL  = 8;
    localparam int HL  = 20;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] sw;
    logic [1:0] sw_al;
    logic [1:0] a_sw, a_pr, a_rl, a_ho;
    logic [1:0] b_sw, b_pr, b_rl, b_ho;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    debounce_switch_bank #(
        .NUM_SWITCHES  (NSW),
        .DEBOUNCE_LIMIT(DL),
        .HOLD_LIMIT    (HL),
        .ACTIVE_LOW    (1'b0)
    ) dut (
        .i_Clk    (clk),
        .i_Reset  (rst),
        .i_Switch (sw),
        .o_Switch (a_sw),
        .o_Press  (a_pr),
        .o_Release(a_rl),
        .o_Hold   (a_ho)
    );

    debounce_switch_bank #(
        .NUM_SWITCHES  (NSW),
        .DEBOUNCE_LIMIT(DL),
        .HOLD_LIMIT    (HL),
        .ACTIVE_LOW    (1'b1)
    ) dut_al (
        .i_Clk    (clk),
        .i_Reset  (rst),
        .i_Switch (sw_al),
        .o_Switch (b_sw),
        .o_Press  (b_pr),
        .o_Release(b_rl),
        .o_Hold   (b_ho)
    );

    // Model of one channel: pin delayed two edges, run length of disagreeing samples,
    // number of edges the level has been high.
    typedef struct packed {
        logic d1;
        logic d2;
        logic st;
        logic pr;
        logic rl;
        logic ho;
        int   run;
        int   high;
    } chan_t;

    chan_t m [2][2];

    function automatic chan_t step(chan_t o, logic pin, logic r);
        chan_t n;
        logic  s;
        int    run;
        n = o;
        if (r) begin
            n = '0;
            return n;
        end
        s    = o.d2;
        n.d1 = pin;
        n.d2 = o.d1;
        run  = (s != o.st) ? o.run + 1 : 0;
        if (run == DL) begin
            n.st = s;
            run  = 0;
        end
        n.run  = run;
        n.pr   = n.st & ~o.st;
        n.rl   = ~n.st & o.st;
        n.high = o.st ? o.high + 1 : 0;
        n.ho   = (n.high == HL) && n.st;
        return n;
    endfunction

    always @(posedge clk) begin
        for (int u = 0; u < 2; u++) begin
            for (int c = 0; c < 2; c++) begin
                m[u][c] <= step(m[u][c], (u == 0) ? sw[c] : ~sw_al[c], rst);
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
        end
    endtask

    task automatic compare_all();
        check("a_switch",  {30'd0, a_sw}, {30'd0, m[0][1].st, m[0][0].st});
        check("a_press",   {30'd0, a_pr}, {30'd0, m[0][1].pr, m[0][0].pr});
        check("a_release", {30'd0, a_rl}, {30'd0, m[0][1].rl, m[0][0].rl});
        check("a_hold",    {30'd0, a_ho}, {30'd0, m[0][1].ho, m[0][0].ho});
        check("b_switch",  {30'd0, b_sw}, {30'd0, m[1][1].st, m[1][0].st});
        check("b_press",   {30'd0, b_pr}, {30'd0, m[1][1].pr, m[1][0].pr});
        check("b_release", {30'd0, b_rl}, {30'd0, m[1][1].rl, m[1][0].rl});
        check("b_hold",    {30'd0, b_ho}, {30'd0, m[1][1].ho, m[1][0].ho});
    endtask

    task automatic tick();
        @(negedge clk);
        compare_all();
    endtask

    // Counts edges until the selected debounced bit is seen high (bounded).
    task automatic wait_sw(input int u, input int c, output int n);
        logic [1:0] v;
        n = 0;
        while (n < 30) begin
            tick();
            n++;
            v = (u == 0) ? a_sw : b_sw;
            if (v[c]) break;
        end
    endtask

    initial begin
        int n;
        int k;
        int cnt_a;
        int cnt_b;
        int cnt_c;

        rst   = 1'b1;
        sw    = 2'b00;
        sw_al = 2'b11;
        tick();
        tick();
        check("reset_a", {24'd0, a_sw, a_pr, a_rl, a_ho}, 32'd0);
        check("reset_b", {24'd0, b_sw, b_pr, b_rl, b_ho}, 32'd0);
        rst = 1'b0;
        repeat (3) tick();

        // Clean press, then long hold and release.
        sw[0] = 1'b1;
        wait_sw(0, 0, n);
        check("press_latency", n, 10);
        check("press_strobe", {30'd0, a_pr}, 32'd1);
        check("ch1_idle", {30'd0, a_sw[1], a_pr[1]}, 32'd0);
        k = 0;
        while (k < 40) begin
            tick();
            k++;
            if (k == 1) check("press_width", {30'd0, a_pr}, 32'd0);
            if (a_ho[0]) break;
        end
        check("hold_delay", k, 20);
        cnt_a = 0;
        repeat (20) begin
            tick();
            cnt_a += int'(a_ho[0]);
        end
        check("hold_once", cnt_a, 0);

        sw[0] = 1'b0;
        cnt_a = 0;
        cnt_b = 0;
        repeat (20) begin
            tick();
            cnt_a += int'(a_rl[0]);
            cnt_b += int'(a_ho[0]);
        end
        check("release_count", cnt_a, 1);
        check("no_hold_after_release", cnt_b, 0);
        check("released_level", {30'd0, a_sw}, 32'd0);

        // Short press: level high about 15 cycles, below the hold limit.
        cnt_a = 0;
        cnt_b = 0;
        sw[0] = 1'b1;
        repeat (15) begin
            tick();
            cnt_a += int'(a_pr[0]);
            cnt_b += int'(a_ho[0]);
        end
        sw[0] = 1'b0;
        repeat (20) begin
            tick();
            cnt_a += int'(a_pr[0]);
            cnt_b += int'(a_ho[0]);
        end
        check("short_press_count", cnt_a, 1);
        check("short_press_no_hold", cnt_b, 0);

        // Bounce: 5 high / 1 low never reaches the 8-sample run.
        cnt_c = 0;
        repeat (10) begin
            sw[0] = 1'b1;
            repeat (5) begin
                tick();
                cnt_c += int'(a_sw[0]);
            end
            sw[0] = 1'b0;
            tick();
            cnt_c += int'(a_sw[0]);
        end
        check("bounce_stable", cnt_c, 0);
        sw[0] = 1'b1;
        wait_sw(0, 0, n);
        check("bounce_latency", n, 10);
        sw[0] = 1'b0;
        repeat (20) tick();

        // Reset after 5 counting cycles on channel 1.
        sw[1] = 1'b1;
        repeat (7) tick();
        rst = 1'b1;
        tick();
        check("reset_mid", {24'd0, a_sw, a_pr, a_rl, a_ho}, 32'd0);
        rst = 1'b0;
        wait_sw(0, 1, n);
        check("reset_recount", n, 10);
        sw[1] = 1'b0;
        repeat (20) tick();

        // Both channels together.
        sw = 2'b11;
        wait_sw(0, 0, n);
        check("parallel_latency", n, 10);
        check("parallel_switch", {30'd0, a_sw}, 32'd3);
        check("parallel_press", {30'd0, a_pr}, 32'd3);
        sw = 2'b00;
        repeat (20) tick();

        // Active-low instance: released pins are high.
        check("al_idle", {24'd0, b_sw, b_pr, b_rl, b_ho}, 32'd0);
        sw_al = 2'b10;
        wait_sw(1, 0, n);
        check("al_latency", n, 10);
        check("al_switch", {30'd0, b_sw}, 32'd1);
        check("al_press", {30'd0, b_pr}, 32'd1);
        sw_al = 2'b11;
        repeat (20) tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
